// File: rtl/dp_pkg.sv
// Shared definitions for the 16-bit distribution datapath: word width and
// channel select encoding used by the 1-to-4 stream demultiplexer.
package dp_pkg;

  localparam int DP_WIDTH = 16;
  localparam int NUM_CH   = 4;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } ch_e;

  // One-hot channel enable for a {s1,s0} select pair.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel synchronous FIFO. Head word is presented combinationally on
// dout; dout reads 0 while empty so nothing undefined leaks after reset.
module demux_chan_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // Storage is data-only; occupancy is tracked by the reset control state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: each input word is routed by
// {s1,s0} into one of four independent channel FIFOs (a, b, c, d).
module demux1to4_stream
  import dp_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready
);

  logic [1:0]        sel;
  logic [NUM_CH-1:0] sel_hot;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] rdy;
  logic [WIDTH-1:0]  dout [NUM_CH];

  assign sel     = {s1, s0};
  assign sel_hot = ch_onehot(sel);

  // in_ready looks only at the selected channel's occupancy, never at consumer readies.
  assign in_ready = !full[sel];
  assign push     = sel_hot & {NUM_CH{in_valid}} & ~full;

  assign rdy = {d_ready, c_ready, b_ready, a_ready};
  assign pop = rdy & ~empty;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    demux_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (in_data),
      .dout  (dout[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  assign a       = dout[CH_A];
  assign b       = dout[CH_B];
  assign c       = dout[CH_C];
  assign d       = dout[CH_D];
  assign a_valid = !empty[CH_A];
  assign b_valid = !empty[CH_B];
  assign c_valid = !empty[CH_C];
  assign d_valid = !empty[CH_D];

endmodule

// File: tb/tb_demux1to4_stream.sv
// Scoreboard bench for demux1to4_stream: directed scenarios plus random soak,
// with a negedge monitor tracking per-channel queues.
module tb_demux1to4_stream;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [3:0]  rdy;
  logic [15:0] a, b, c, d;
  logic        a_valid, b_valid, c_valid, d_valid;

  logic [15:0] dat [4];
  logic [3:0]  vv;
  logic [15:0] q [4][$];
  logic [15:0] route [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux1to4_stream #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s0       (sel[0]),
    .s1       (sel[1]),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .c_valid  (c_valid),
    .d_valid  (d_valid),
    .a_ready  (rdy[0]),
    .b_ready  (rdy[1]),
    .c_ready  (rdy[2]),
    .d_ready  (rdy[3])
  );

  assign dat[0] = a;
  assign dat[1] = b;
  assign dat[2] = c;
  assign dat[3] = d;
  assign vv     = {d_valid, c_valid, b_valid, a_valid};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] dd);
    in_valid = v;
    sel      = s;
    in_data  = dd;
  endtask

  // Scoreboard monitor: pops expected words when a channel hands one over,
  // and records accepted input words into the addressed channel's queue.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sb_in_ready", 32'(in_ready), 32'(q[sel].size() < DEPTH));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("sb_valid_ch%0d", k), 32'(vv[k]), 32'(q[k].size() != 0));
        if (vv[k] && rdy[k] && q[k].size() != 0) begin
          chk($sformatf("sb_data_ch%0d", k), 32'(dat[k]), 32'(q[k][0]));
          void'(q[k].pop_front());
        end
      end
      if (in_valid && in_ready) q[sel].push_back(in_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    route[0] = 16'h1111;
    route[1] = 16'h2222;
    route[2] = 16'h3333;
    route[3] = 16'h4444;
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 16'h0000);
    rdy = 4'hF;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valids", 32'(vv), 0);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_data_ch%0d", k), 32'(dat[k]), 0);
    rst_n = 1'b1;
    look();
    chk("rst_in_ready", 32'(in_ready), 1);

    // Routing
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'b1, 2'(i), route[i]);
      look();
      chk("route_in_ready", 32'(in_ready), 1);
      if (i > 0) begin
        chk("route_valids", 32'(vv), 32'(4'b0001 << (i - 1)));
        chk("route_data", 32'(dat[i-1]), 32'(route[i-1]));
      end
    end
    step();
    in_valid = 1'b0;
    look();
    chk("route_valids_d", 32'(vv), 'h8);
    chk("route_data_d", 32'(d), 'h4444);
    step();
    look();
    chk("route_idle", 32'(vv), 0);

    // Back-pressure on channel b
    rdy = 4'b1101;
    step(); drive(1'b1, 2'b01, 16'hB001); look();
    chk("bp_rdy1", 32'(in_ready), 1);
    step(); drive(1'b1, 2'b01, 16'hB002); look();
    chk("bp_rdy2", 32'(in_ready), 1);
    chk("bp_b_first", 32'(b), 'hB001);
    step(); drive(1'b1, 2'b01, 16'hB003); look();
    chk("bp_full", 32'(in_ready), 0);
    step(); drive(1'b1, 2'b00, 16'hA001); look();
    chk("bp_alt_ready", 32'(in_ready), 1);
    step(); drive(1'b1, 2'b01, 16'hB003); rdy = 4'hF; look();
    chk("bp_a_word", 32'(a), 'hA001);
    chk("bp_b_head1", 32'(b), 'hB001);
    chk("bp_still_full", 32'(in_ready), 0);
    step(); look();
    chk("bp_b_head2", 32'(b), 'hB002);
    chk("bp_reopen", 32'(in_ready), 1);
    step(); in_valid = 1'b0; look();
    chk("bp_b_head3", 32'(b), 'hB003);
    step(); look();
    chk("bp_idle", 32'(vv), 0);

    // Full channel c with simultaneous pop
    rdy = 4'b1011;
    step(); drive(1'b1, 2'b10, 16'hC001);
    step(); drive(1'b1, 2'b10, 16'hC002);
    step(); drive(1'b1, 2'b10, 16'hC003); rdy[2] = 1'b1; look();
    chk("full_pop_ready", 32'(in_ready), 0);
    chk("full_pop_head", 32'(c), 'hC001);
    step(); rdy[2] = 1'b0; look();
    chk("full_after_head", 32'(c), 'hC002);
    chk("full_after_ready", 32'(in_ready), 1);
    step(); in_valid = 1'b0; look();
    chk("full_hold_head", 32'(c), 'hC002);
    step(); rdy = 4'hF; look();
    step(); look();
    chk("full_c003", 32'(c), 'hC003);
    step(); look();
    chk("full_idle", 32'(vv), 0);

    // Ready on empty channel d
    repeat (5) begin
      step(); look();
      chk("empty_d_valid", 32'(d_valid), 0);
    end
    step(); drive(1'b1, 2'b11, 16'hD00D); look();
    chk("empty_push_ready", 32'(in_ready), 1);
    chk("empty_not_yet", 32'(d_valid), 0);
    step(); in_valid = 1'b0; look();
    chk("empty_d_arrive", 32'(d_valid), 1);
    chk("empty_d_data", 32'(d), 'hD00D);
    step(); look();
    chk("empty_d_gone", 32'(d_valid), 0);

    // Reset mid-operation
    rdy = 4'h0;
    step(); drive(1'b1, 2'b00, 16'hAA01);
    step(); drive(1'b1, 2'b00, 16'hAA02);
    step(); drive(1'b1, 2'b10, 16'hCC01);
    step(); in_valid = 1'b0; look();
    chk("mid_loaded", 32'(vv), 'h5);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) q[k].delete();
    #1;
    chk("mid_rst_valids", 32'(vv), 0);
    for (int k = 0; k < 4; k++) chk($sformatf("mid_rst_data_ch%0d", k), 32'(dat[k]), 0);
    step();
    rst_n = 1'b1;
    look();
    chk("mid_rel_ready", 32'(in_ready), 1);
    chk("mid_rel_valids", 32'(vv), 0);
    rdy = 4'hF;
    repeat (2) begin
      step(); look();
      chk("mid_no_ghost", 32'(vv), 0);
    end

    // Random soak
    for (int n = 0; n < 10000; n++) begin
      step();
      in_valid = 1'($urandom_range(0, 1));
      sel      = 2'($urandom);
      in_data  = 16'($urandom);
      rdy      = 4'($urandom);
    end
    step();
    in_valid = 1'b0;
    rdy = 4'hF;
    repeat (6) step();
    look();
    for (int k = 0; k < 4; k++)
      chk($sformatf("soak_drained_ch%0d", k), 32'(q[k].size()), 0);
    chk("soak_final_valids", 32'(vv), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1to4_stream.md
# demux1to4_stream

Registered 1-to-4 demultiplexer for the 16-bit datapath. It routes a valid/ready input stream to one of four output channels, chosen per word by the `s1`/`s0` select pair. Each channel has its own small FIFO, so a stalled consumer blocks only words addressed to that channel. It is the distribution end of the 4:1 selection path: one producer feeds four independent consumers (a, b, c, d).

## Interface
Parameters:
- `WIDTH`, 16, data width of input and every output.
- `DEPTH`, 2, entries per channel FIFO; power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_data` in WIDTH: input word.
- `in_valid` in 1: input word present.
- `in_ready` out 1: input word will be accepted this cycle.
- `s0`, `s1` in 1 each: channel select, sampled with `in_data`. {s1,s0} = 00→a, 01→b, 10→c, 11→d.
- `a`, `b`, `c`, `d` out WIDTH: channel output data, taken from the FIFO head.
- `a_valid`, `b_valid`, `c_valid`, `d_valid` out 1: channel head word present.
- `a_ready`, `b_ready`, `c_ready`, `d_ready` in 1: consumer takes the head word.

## Operation
- Selected channel `k` = {s1,s0}.
- Push: `in_valid && in_ready` writes `in_data` into FIFO `k`.
- Input ready: `in_ready` = FIFO `k` not full.
  - No combinational path from any `*_ready` input to `in_ready`.
  - `in_ready` may depend combinationally on s1/s0.
- Pop: `x_valid && x_ready` on channel x removes its head word.
- Ready without valid is ignored; count stays at 0, no underflow.
- Simultaneous push and pop on the same channel:
  - Both take effect and the occupancy is unchanged.
  - This includes a full channel, but only if the push was already permitted.
  - A full channel still drives `in_ready`=0 even while it is popping.
- Independent channels: pushes into one channel and pops on the other three all proceed in the same cycle.
- Ordering: order is preserved within each channel. No ordering exists across channels.
- Output data:
  - `x` = head entry of channel x whenever `x_valid`=1.
  - `x` is don't-care when `x_valid`=0, but must not be X after reset; it holds the last value or 0.
- Pointers: per channel, log2(DEPTH)-bit read and write pointers wrap modulo DEPTH. A count of log2(DEPTH)+1 bits gives full (count==DEPTH) and empty (count==0).
- Reset (asserted at any time, including mid-transfer):
  - All FIFOs are flushed immediately: counts and pointers go to 0.
  - All `*_valid` outputs go to 0.
  - Data outputs go to 0.
  - `in_ready` reads 1 once reset is released, since all channels are empty.
  - Words in flight are discarded; there is no partial transfer.

## Timing
- Latency: a word accepted on edge N appears on its channel with `x_valid`=1 after edge N. That is 1 cycle, provided the channel was empty.
- Behind queued words, a word appears after the words ahead of it pop.
- Throughput:
  - One word per cycle into any channel whose consumer holds ready high.
  - With a DEPTH=2 channel whose consumer is stalled: two words are accepted, then `in_ready`=0 while that channel is selected.
- Reset values: `in_ready`=1 (after release), all `*_valid`=0, `a`/`b`/`c`/`d`=0.
- Handshake rule: `x_valid` and `x` stay stable until the cycle of a pop. A producer must hold `in_data`, `s0` and `s1` stable while `in_valid`=1 and `in_ready`=0.

## Structure
- Shared package `dp_pkg`:
  - `DP_WIDTH`=16.
  - Channel select encoding constants `CH_A`..`CH_D` (0..3).
- Sub-module `demux_chan_fifo`:
  - One synchronous FIFO with `push`, `pop`, `din`, `dout`, `full`, `empty`, async active-low reset.
  - Instantiated four times.
- Top level contains only:
  - Select decode to four push enables, each gated by `in_valid && !full[k]`.
  - The `in_ready` mux.
  - Valid/ready wiring per channel.

## Test plan
- Routing:
  - Stimulus: drive 0x1111/00, 0x2222/01, 0x3333/10, 0x4444/11 on consecutive cycles, all readies=1.
  - Response: each appears one cycle after acceptance on a, b, c, d respectively; no word appears on any other channel.
- Back-pressure:
  - Stimulus: `b_ready`=0; send 0xB001, 0xB002, 0xB003 to select 01.
  - Response: the first two are accepted; `in_ready`=0 on the third. Switching select to 00 with 0xA001 is accepted next cycle. Raising `b_ready` drains 0xB001 then 0xB002 in order, after which 0xB003 is accepted.
- Full with simultaneous pop:
  - Stimulus: channel c full (0xC001, 0xC002); in the same cycle `c_ready`=1 and `in_valid`=1 to select 10.
  - Response: pop occurs and `in_ready`=0 (no push). Next cycle the count is 1 and 0xC003 is accepted.
- Empty pop:
  - Stimulus: `d_ready`=1 with channel d empty for 5 cycles, then one push of 0xD00D.
  - Response: `d_valid` stays 0, then `d`=0xD00D valid exactly one cycle after acceptance.
- Reset mid-operation:
  - Stimulus: load 2 words in a and 1 word in c; assert `rst_n`=0 between edges.
  - Response: all valids drop immediately and all data outputs are 0. After release, `in_ready`=1 and the old words never reappear.
- Random soak:
  - Stimulus: 10,000 cycles of random valid, select and readies.
  - Response: a scoreboard matches per-channel order. `in_ready` is never 1 with the selected channel full, and there is no loss or duplication.
